// File: rtl/pacman_pkg.sv
// pacman_pkg: encodings shared by the game logic and the sprite renderer.
package pacman_pkg;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;
    localparam logic [2:0] SPR_NONE   = 3'd0;
    localparam logic [2:0] SPR_PACMAN = 3'd1;
    localparam logic [2:0] SPR_BLINKY = 3'd2;
    localparam logic [2:0] SPR_PINKY  = 3'd3;
    localparam logic [2:0] SPR_INKY   = 3'd4;
    localparam logic [2:0] SPR_CLYDE  = 3'd5;
    typedef enum logic [1:0] {OR_RIGHT, OR_UP, OR_DOWN, OR_LEFT} orient_t;
    typedef enum logic [1:0] {ALIVE, DYING, DEAD} death_state_t;
    function automatic orient_t dir_to_orient(input logic [3:0] dir);
        return dir == DIR_UP ? OR_UP : dir == DIR_DOWN ? OR_DOWN : dir == DIR_LEFT ? OR_LEFT : OR_RIGHT;
    endfunction
endpackage

// File: rtl/sprite_box_hit.sv
// sprite_box_hit: registered box test and in-box offset for one sprite.
module sprite_box_hit #(
    parameter int SPRITE_SIZE = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic        hit,
    output logic [4:0]  u,
    output logic [4:0]  v
);
    logic [11:0] x_end;
    logic [10:0] y_end;
    // one extra bit so a box at the far edge does not wrap to 0
    assign x_end = {1'b0, x} + 12'(SPRITE_SIZE - 1);
    assign y_end = {1'b0, y} + 11'(SPRITE_SIZE - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            hit <= 1'b0;
            u   <= '0;
            v   <= '0;
        end else begin
            hit <= hcount >= x && {1'b0, hcount} <= x_end && vcount >= y && {1'b0, vcount} <= y_end;
            u   <= 5'(hcount - x);
            v   <= 5'(vcount - y);
        end
endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer: per-frame sprite snapshot, 2-cycle pixel hit pipeline with
// fixed priority, and the pacman death-blink sequence.
module sprite_renderer
    import pacman_pkg::*;
#(
    parameter int SPRITE_SIZE  = 32,
    parameter int DEATH_FRAMES = 60,
    parameter int FLASH_PERIOD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [10:0] pacman_pos_x,
    input  logic [10:0] blinky_pos_x,
    input  logic [10:0] pinky_pos_x,
    input  logic [10:0] inky_pos_x,
    input  logic [10:0] clyde_pos_x,
    input  logic [9:0]  pacman_pos_y,
    input  logic [9:0]  blinky_pos_y,
    input  logic [9:0]  pinky_pos_y,
    input  logic [9:0]  inky_pos_y,
    input  logic [9:0]  clyde_pos_y,
    input  logic        pacman_is_dead,
    input  logic [3:0]  pacman_moving_dir,
    output logic        pix_valid_out,
    output logic [2:0]  sprite_id,
    output logic [4:0]  pix_u,
    output logic [4:0]  pix_v,
    output logic [1:0]  pac_orient,
    output logic        game_over
);
    localparam int FB = $clog2(FLASH_PERIOD);
    localparam int CW = $clog2(DEATH_FRAMES) > FB ? $clog2(DEATH_FRAMES) : FB + 1;

    logic [10:0]  pos_x [5];
    logic [9:0]   pos_y [5];
    logic [10:0]  snap_x [5];
    logic [9:0]   snap_y [5];
    orient_t      orient;
    logic [4:0]   hit;
    logic [4:0]   hu [5];
    logic [4:0]   hv [5];
    logic         v1;
    death_state_t state;
    logic [CW-1:0] frame_cnt, cnt_inc;
    logic         pac_visible;
    logic [2:0]   sel_id;
    logic [4:0]   sel_u, sel_v;

    assign pos_x = '{pacman_pos_x, blinky_pos_x, pinky_pos_x, inky_pos_x, clyde_pos_x};
    assign pos_y = '{pacman_pos_y, blinky_pos_y, pinky_pos_y, inky_pos_y, clyde_pos_y};
    assign pac_orient = orient;
    assign cnt_inc = frame_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int i = 0; i < 5; i++) begin
                snap_x[i] <= '0;
                snap_y[i] <= '0;
            end
            orient <= OR_RIGHT;
        end else if (frame_start) begin
            snap_x <= pos_x;
            snap_y <= pos_y;
            if ($onehot(pacman_moving_dir)) orient <= dir_to_orient(pacman_moving_dir);
        end

    for (genvar k = 0; k < 5; k++) begin : g_box
        sprite_box_hit #(.SPRITE_SIZE(SPRITE_SIZE)) u_box (
            .clk(clk), .rst(rst), .x(snap_x[k]), .y(snap_y[k]),
            .hcount(hcount), .vcount(vcount), .hit(hit[k]), .u(hu[k]), .v(hv[k])
        );
    end

    // the first FLASH_PERIOD frames of dying are hidden, then it alternates
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state       <= ALIVE;
            frame_cnt   <= '0;
            pac_visible <= 1'b1;
            game_over   <= 1'b0;
        end else if (frame_start)
            case (state)
                ALIVE:
                    if (pacman_is_dead) begin
                        state       <= DYING;
                        frame_cnt   <= '0;
                        pac_visible <= 1'b0;
                    end
                DYING:
                    if (frame_cnt == CW'(DEATH_FRAMES - 1)) begin
                        state       <= DEAD;
                        pac_visible <= 1'b0;
                        game_over   <= 1'b1;
                    end else begin
                        frame_cnt   <= cnt_inc;
                        pac_visible <= cnt_inc[FB];
                    end
                default: ;
            endcase

    always_comb begin
        sel_id = SPR_NONE;
        sel_u  = '0;
        sel_v  = '0;
        for (int i = 4; i >= 0; i--)
            if (hit[i] && (i != 0 || pac_visible)) begin
                sel_id = 3'(i + 1);
                sel_u  = hu[i];
                sel_v  = hv[i];
            end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            v1            <= 1'b0;
            pix_valid_out <= 1'b0;
            sprite_id     <= SPR_NONE;
            pix_u         <= '0;
            pix_v         <= '0;
        end else begin
            v1            <= pix_valid;
            pix_valid_out <= v1;
            sprite_id     <= v1 ? sel_id : SPR_NONE;
            pix_u         <= v1 ? sel_u : 5'd0;
            pix_v         <= v1 ? sel_v : 5'd0;
        end
endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: directed and randomized checks against a frame-level
// reference model of sprite hits, priority, orientation and the death sequence.
module tb_sprite_renderer;
    logic        clk = 0, rst = 1, frame_start = 0, pix_valid = 0, pacman_is_dead = 0;
    logic [10:0] hcount = 0;
    logic [9:0]  vcount = 0;
    logic [3:0]  dir = 0;
    logic [10:0] in_x [5];
    logic [9:0]  in_y [5];
    logic        pix_valid_out, game_over;
    logic [2:0]  sprite_id;
    logic [4:0]  pix_u, pix_v;
    logic [1:0]  pac_orient;
    int checks = 0, errors = 0;

    typedef struct {int valid; int id; int u; int v;} exp_t;
    exp_t q[$];
    int mx[5], my[5];
    int m_orient, m_state, m_k;

    always #5 clk = ~clk;

    sprite_renderer dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .hcount(hcount), .vcount(vcount),
        .pacman_pos_x(in_x[0]), .blinky_pos_x(in_x[1]), .pinky_pos_x(in_x[2]),
        .inky_pos_x(in_x[3]), .clyde_pos_x(in_x[4]),
        .pacman_pos_y(in_y[0]), .blinky_pos_y(in_y[1]), .pinky_pos_y(in_y[2]),
        .inky_pos_y(in_y[3]), .clyde_pos_y(in_y[4]),
        .pacman_is_dead(pacman_is_dead), .pacman_moving_dir(dir),
        .pix_valid_out(pix_valid_out), .sprite_id(sprite_id), .pix_u(pix_u), .pix_v(pix_v),
        .pac_orient(pac_orient), .game_over(game_over)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // model state: 0 alive, 1 dying (m_k frames in), 2 dead
    function automatic bit visible();
        return m_state == 0 ? 1'b1 : m_state == 1 ? ((m_k / 8) % 2 == 1) : 1'b0;
    endfunction

    function automatic exp_t predict(input bit pv, input int h, input int v);
        exp_t e = '{0, 0, 0, 0};
        if (!pv) return e;
        e.valid = 1;
        for (int k = 0; k < 5; k++)
            if (e.id == 0 && (k != 0 || visible()) && h >= mx[k] && h <= mx[k] + 31 && v >= my[k] && v <= my[k] + 31) begin
                e.id = k + 1;
                e.u  = h - mx[k];
                e.v  = v - my[k];
            end
        return e;
    endfunction

    task automatic model_frame();
        for (int k = 0; k < 5; k++) begin
            mx[k] = int'(in_x[k]);
            my[k] = int'(in_y[k]);
        end
        case (dir)
            4'b0001: m_orient = 0;
            4'b0010: m_orient = 1;
            4'b0100: m_orient = 2;
            4'b1000: m_orient = 3;
            default: ;
        endcase
        if (m_state == 0) begin
            if (pacman_is_dead) begin
                m_state = 1;
                m_k = 0;
            end
        end else if (m_state == 1) begin
            if (m_k == 59) m_state = 2;
            else m_k++;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            mx[k] = 0;
            my[k] = 0;
        end
        m_orient = 0;
        m_state = 0;
        m_k = 0;
        q.delete();
        q.push_back('{0, 0, 0, 0});
    endtask

    task automatic cycle(input bit fs, input bit pv, input int h, input int v);
        exp_t e;
        frame_start = fs;
        pix_valid = pv;
        hcount = 11'(h);
        vcount = 10'(v);
        q.push_back(predict(pv, h, v));
        @(posedge clk);
        if (fs) model_frame();
        #1;
        e = q.pop_front();
        check("valid", pix_valid_out, e.valid);
        check("id", sprite_id, e.id);
        check("u", pix_u, e.u);
        check("v", pix_v, e.v);
        check("orient", pac_orient, m_orient);
        check("game_over", game_over, m_state == 2 ? 1 : 0);
        frame_start = 0;
        pix_valid = 0;
    endtask

    task automatic pix(input int h, input int v);
        cycle(0, 1, h, v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic frame();
        cycle(1, 0, 0, 0);
    endtask

    task automatic set_pos(input int k, input int x, input int y);
        in_x[k] = 11'(x);
        in_y[k] = 10'(y);
    endtask

    task automatic rand_pixel(output int h, output int v);
        int k = $urandom_range(0, 4);
        if ($urandom_range(0, 4) == 0) begin
            h = $urandom_range(0, 2047);
            v = $urandom_range(0, 1023);
        end else begin
            h = (mx[k] + int'($urandom_range(0, 39)) - 4) & 2047;
            v = (my[k] + int'($urandom_range(0, 39)) - 4) & 1023;
        end
    endtask

    initial begin
        int h, v;
        for (int k = 0; k < 5; k++) set_pos(k, 0, 0);
        model_reset();
        #3 rst = 0;
        #1;
        check("rst_valid", pix_valid_out, 0);
        check("rst_id", sprite_id, 0);
        check("rst_orient", pac_orient, 0);
        check("rst_game_over", game_over, 0);
        @(negedge clk) rst = 1;

        // single pacman hit and box edges
        set_pos(0, 967, 66);
        frame();
        pix(970, 70);
        pix(998, 97);
        pix(999, 66);
        pix(966, 66);
        pix(967, 98);
        idle(2);

        // blinky/pinky overlap, then snapshot timing
        set_pos(1, 615, 258);
        set_pos(2, 615, 258);
        frame();
        pix(620, 260);
        set_pos(1, 700, 258);
        pix(620, 260);
        idle(1);
        cycle(1, 1, 620, 260);
        pix(620, 260);
        pix(705, 260);
        set_pos(0, 615, 258);
        frame();
        pix(620, 260);
        idle(2);

        // far-edge boxes must not wrap
        set_pos(3, 2040, 1010);
        set_pos(4, 2047, 1023);
        frame();
        pix(2047, 1023);
        pix(0, 0);
        pix(5, 3);
        idle(2);

        // randomized alive-phase frames
        for (int f = 0; f < 25; f++) begin
            for (int k = 0; k < 5; k++)
                if (k > 0 && $urandom_range(0, 3) == 0) set_pos(k, int'(in_x[k-1]), int'(in_y[k-1]));
                else set_pos(k, $urandom_range(0, 2047), $urandom_range(0, 1023));
            dir = 4'($urandom_range(0, 15));
            frame();
            for (int i = 0; i < 14; i++) begin
                rand_pixel(h, v);
                cycle(0, $urandom_range(0, 3) != 0, h, v);
            end
        end

        // death sequence: dead flag dropped after 3 frames
        set_pos(0, 100, 100);
        dir = 4'b0001;
        pacman_is_dead = 1;
        frame();
        for (int f = 0; f < 64; f++) begin
            if (f == 3) pacman_is_dead = 0;
            if (f != 0) frame();
            for (int i = 0; i < 5; i++)
                cycle(0, $urandom_range(0, 4) != 0, 100 + $urandom_range(0, 33), 100 + $urandom_range(0, 31));
            pix(100, 100);
            idle(1);
        end

        // orientation hold on invalid direction
        dir = 4'b1000;
        frame();
        dir = 4'b0000;
        frame();
        dir = 4'b0110;
        frame();
        pix(100, 100);

        // asynchronous reset mid-stream
        pix(101, 101);
        rst = 0;
        #1;
        check("arst_valid", pix_valid_out, 0);
        check("arst_id", sprite_id, 0);
        check("arst_u", pix_u, 0);
        check("arst_v", pix_v, 0);
        check("arst_orient", pac_orient, 0);
        check("arst_game_over", game_over, 0);
        model_reset();
        @(negedge clk) rst = 1;
        idle(2);
        pix(5, 5);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
